// File: rtl/dbg_mem_arbiter.sv
// Shares the data-memory port between the core LSU and the debug module.
// Debug accesses stall the core, drain its outstanding requests, then issue one access.
module dbg_mem_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned MAX_OUT = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [AW-1:0]     core_addr_i,
   input  logic [DW-1:0]     core_wdata_i,
   input  logic [DW/8-1:0]   core_be_i,
   output logic              core_gnt_o,
   output logic              core_rvalid_o,
   output logic [DW-1:0]     core_rdata_o,
   output logic              core_hold_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [AW-1:0]     dbg_addr_i,
   input  logic [DW-1:0]     dbg_wdata_i,
   output logic              dbg_rvalid_o,
   output logic [DW-1:0]     dbg_rdata_o,
   output logic              dbg_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [AW-1:0]     mem_addr_o,
   output logic [DW-1:0]     mem_wdata_o,
   output logic [DW/8-1:0]   mem_be_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DW-1:0]     mem_rdata_i
);

   localparam int unsigned CW = $clog2(MAX_OUT + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_CORE,
      S_DRAIN,
      S_DBG_REQ,
      S_DBG_WAIT,
      S_DBG_DONE
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [TW-1:0]   r_tmo;
   logic            r_dbg_rvalid;
   logic            r_dbg_err;
   logic [DW-1:0]   r_dbg_rdata;

   logic w_in_core;
   logic w_in_dbg_req;
   logic w_slot;
   logic w_tmo_hit;
   logic w_core_issue;
   logic w_core_acc;
   logic w_core_rsp;
   logic w_dbg_issue;

   assign w_in_core    = (r_state == S_CORE);
   assign w_in_dbg_req = (r_state == S_DBG_REQ);
   assign w_slot       = (r_cnt < CW'(MAX_OUT));
   assign w_tmo_hit    = (r_tmo == TW'(TIMEOUT - 1));
   assign w_core_issue = w_in_core & ~dbg_req_i & core_req_i & w_slot;
   assign w_core_acc   = w_core_issue & mem_gnt_i;
   // The request is withdrawn on the abort cycle so no orphan access is granted.
   assign w_dbg_issue  = w_in_dbg_req & ~w_tmo_hit;
   // Responses only belong to the core while it has something outstanding.
   assign w_core_rsp   = mem_rvalid_i & (w_in_core | (r_state == S_DRAIN)) & (r_cnt != '0);

   assign mem_req_o     = w_core_issue | w_dbg_issue;
   assign mem_we_o      = w_in_dbg_req ? dbg_we_i    : core_we_i;
   assign mem_addr_o    = w_in_dbg_req ? dbg_addr_i  : core_addr_i;
   assign mem_wdata_o   = w_in_dbg_req ? dbg_wdata_i : core_wdata_i;
   assign mem_be_o      = w_in_dbg_req ? '1          : core_be_i;

   assign core_gnt_o    = w_core_acc;
   assign core_rvalid_o = w_core_rsp;
   assign core_rdata_o  = mem_rdata_i;
   assign core_hold_o   = ~w_in_core | dbg_req_i;

   assign dbg_rvalid_o  = r_dbg_rvalid;
   assign dbg_rdata_o   = r_dbg_rdata;
   assign dbg_err_o     = r_dbg_err;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= S_CORE;
         r_cnt        <= '0;
         r_tmo        <= '0;
         r_dbg_rvalid <= 1'b0;
         r_dbg_err    <= 1'b0;
         r_dbg_rdata  <= '0;
      end else begin
         r_dbg_rvalid <= 1'b0;

         if (w_core_acc && !w_core_rsp) begin
            r_cnt <= r_cnt + CW'(1);
         end else if (!w_core_acc && w_core_rsp) begin
            r_cnt <= r_cnt - CW'(1);
         end

         if (w_in_dbg_req || (r_state == S_DBG_WAIT)) begin
            r_tmo <= r_tmo + TW'(1);
         end

         case (r_state)
            S_CORE: begin
               if (dbg_req_i) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if ((r_cnt == '0) || ((r_cnt == CW'(1)) && mem_rvalid_i)) begin
                  r_state     <= S_DBG_REQ;
                  r_tmo       <= '0;
                  r_dbg_err   <= 1'b0;
                  r_dbg_rdata <= '0;
               end
            end
            S_DBG_REQ: begin
               if (w_tmo_hit) begin
                  r_state      <= S_DBG_DONE;
                  r_dbg_rvalid <= 1'b1;
                  r_dbg_err    <= 1'b1;
                  r_dbg_rdata  <= '0;
               end else if (mem_gnt_i) begin
                  r_state <= S_DBG_WAIT;
               end
            end
            S_DBG_WAIT: begin
               // A response arriving on the last allowed cycle still wins over the abort.
               if (mem_rvalid_i) begin
                  r_state      <= S_DBG_DONE;
                  r_dbg_rvalid <= 1'b1;
                  r_dbg_rdata  <= dbg_we_i ? '0 : mem_rdata_i;
               end else if (w_tmo_hit) begin
                  r_state      <= S_DBG_DONE;
                  r_dbg_rvalid <= 1'b1;
                  r_dbg_err    <= 1'b1;
                  r_dbg_rdata  <= '0;
               end
            end
            S_DBG_DONE: begin
               if (!dbg_req_i) begin
                  r_state <= S_CORE;
               end
            end
            default: r_state <= S_CORE;
         endcase
      end
   end

endmodule
